obj_linebuf_scanout: RTL
========================

OBJ_LINEBUF_SCANOUT -- requirements
Module: obj_linebuf_scanout

Interface
REQ-001 Parameter LINE_PAIRS, 128, number of even/odd pixel pairs per line (256 px).
REQ-002 Parameter ADDR_W, 7, pair address width; LINE_PAIRS SHALL NOT exceed 2**ADDR_W.
REQ-003 i_EMU_MCLK  input  1  master clock; one clock; all state updates on its rising edge.
REQ-004 i_EMU_RST  input  1  reset, asynchronous, active-high.
REQ-005 i_EMU_CLK6MPCEN_n  input  1  pixel clock enable, active low; an "enable" is an i_EMU_MCLK rising edge with this signal low.
REQ-006 i_LINESTART  input  1  sampled on enables; starts scanout of one line.
REQ-007 i_FLIP  input  1  horizontal flip, sampled only with i_LINESTART.
REQ-008 i_ERASE_EN  input  1  enables erase-after-read.
REQ-009 o_BANK  output  1  line buffer bank being scanned; the writer uses ~o_BANK.
REQ-010 o_RDADDR  output  ADDR_W  read pair address to the synchronous line buffer RAM.
REQ-011 i_QA, i_QB  input  8 each  RAM read data, lane A (even x) and lane B (odd x), {palette[3:0], pixel[3:0]}.
REQ-012 o_WRADDR  output  ADDR_W  erase write pair address.
REQ-013 o_ERASE_n  output  1  active-low erase strobe; RAM writes 0x00 to both lanes at o_WRADDR.
REQ-014 o_PIXEL  output  8  scanned pixel {palette, pixel}.
REQ-015 o_OPAQUE  output  1  high when o_PIXEL[3:0] != 0.

Function
REQ-016 No register SHALL change on non-enable edges; all cycle counts below are in enables.
REQ-017 States: IDLE, WAIT, RUN0, RUN1.
REQ-018 i_LINESTART high at enable k, any state: toggle o_BANK, latch i_FLIP, o_RDADDR := 0 (unflipped) or LINE_PAIRS-1 (flipped), enter WAIT.
REQ-019 WAIT -> RUN0 unconditionally after one enable (RAM read latency of one enable).
REQ-020 RUN0: capture {i_QA,i_QB} into a pair register; o_PIXEL := lane A (unflipped) or lane B (flipped); current pair address -> o_WRADDR; o_ERASE_n low for this enable only if i_ERASE_EN; step o_RDADDR (+1 unflipped, -1 flipped) unless current pair is last; -> RUN1.
REQ-021 RUN1: o_PIXEL := the other lane from the pair register; o_ERASE_n high; -> IDLE after last pair, else RUN0.
REQ-022 First pixel valid on o_PIXEL after enable k+2; pixel n valid after enable k+2+n; 2*LINE_PAIRS pixels per line.
REQ-023 IDLE: o_PIXEL = 0x00, o_OPAQUE = 0, o_ERASE_n = 1, o_RDADDR holds.
REQ-024 o_PIXEL and o_OPAQUE SHALL be registered and consistent in the same cycle.
REQ-025 i_LINESTART coinciding with RUN0/RUN1 aborts the line: REQ-018 takes priority, no erase issued on that enable, remaining pairs are not erased.
REQ-026 i_LINESTART on the final RUN1 enable: restart wins; no IDLE cycle.
REQ-027 i_FLIP changes outside i_LINESTART SHALL have no effect on the current line.
REQ-028 Address arithmetic SHALL never wrap: last pair is LINE_PAIRS-1 (unflipped) or 0 (flipped).

Reset
REQ-029 While i_EMU_RST high: state IDLE, o_BANK 0, o_RDADDR 0, o_WRADDR 0, o_ERASE_n 1, o_PIXEL 0x00, o_OPAQUE 0, pair register 0, flip latch 0.
REQ-030 Reset asserted mid-line SHALL take effect immediately; no further erase strobe for that line.

Structure
REQ-031 State encoding and LINE_PAIRS default SHALL reside in the shared video package used by the object pipeline.
REQ-032 Single module; no sub-module required.

Verification
REQ-033 Unflipped, RAM preloaded pair p = {A=p, B=p+0x80}: LINESTART -> o_PIXEL 0x00,0x80,0x01,0x81,... from enable k+2; 256 pixels; then IDLE, 0x00.
REQ-034 Flipped, same data: sequence 0xFF,0x7F,0xFE,0x7E,... ending 0x80,0x00; o_RDADDR 127 down to 0.
REQ-035 i_ERASE_EN=1: after the line all RAM words read 0x00; exactly 128 single-enable o_ERASE_n pulses; with i_ERASE_EN=0, none, RAM unchanged.
REQ-036 LINESTART at pair 40 of line: o_BANK toggles, scan restarts at 0, pairs 41..127 of old bank stay intact.
REQ-037 i_EMU_CLK6MPCEN_n held high 5 clocks mid-line: all outputs frozen, sequence resumes without loss.
REQ-038 i_EMU_RST pulse mid-line: outputs 0x00/0/1 asynchronously, o_BANK 0, IDLE until next LINESTART.

Source files
------------

// File: rtl/obj_linebuf_scanout_pkg.sv
// Shared video package for the object pipeline.
// Holds the line-buffer scanout state encoding and the default line geometry.
package obj_linebuf_scanout_pkg;

    // Default line geometry: 128 even/odd pairs = 256 pixels.
    localparam int unsigned LINE_PAIRS_DEFAULT = 128;
    localparam int unsigned ADDR_W_DEFAULT     = 7;
    localparam int unsigned PIX_W              = 8;
    localparam int unsigned PAIR_W             = 2 * PIX_W;

    // Scanout state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN0 = 2'd2;
    localparam logic [1:0] ST_RUN1 = 2'd3;

endpackage

// File: rtl/obj_linebuf_scanout.sv
// Object line buffer scanout.
// Reads one bank of a dual-lane (even/odd) line buffer RAM a pair per two
// pixel enables, serialises the pair into o_PIXEL (optionally mirrored), and
// optionally erases each pair after it has been read.
// Ports:
//   i_EMU_MCLK, i_EMU_RST           master clock, async active-high reset
//   i_EMU_CLK6MPCEN_n               pixel enable, active low
//   i_LINESTART, i_FLIP, i_ERASE_EN line control
//   o_BANK                          bank being scanned (writer uses ~o_BANK)
//   o_RDADDR, i_QA, i_QB            RAM read port (one enable latency)
//   o_WRADDR, o_ERASE_n             RAM erase port (writes 0x00 to both lanes)
//   o_PIXEL, o_OPAQUE               scanned pixel and non-transparent flag
module obj_linebuf_scanout
    import obj_linebuf_scanout_pkg::*;
#(
    parameter int unsigned LINE_PAIRS = LINE_PAIRS_DEFAULT,
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_RST,
    input  logic              i_EMU_CLK6MPCEN_n,
    input  logic              i_LINESTART,
    input  logic              i_FLIP,
    input  logic              i_ERASE_EN,
    output logic              o_BANK,
    output logic [ADDR_W-1:0] o_RDADDR,
    input  logic [PIX_W-1:0]  i_QA,
    input  logic [PIX_W-1:0]  i_QB,
    output logic [ADDR_W-1:0] o_WRADDR,
    output logic              o_ERASE_n,
    output logic [PIX_W-1:0]  o_PIXEL,
    output logic              o_OPAQUE
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(LINE_PAIRS - 1);

    logic              pix_en;
    logic [1:0]        state_q,   state_d;
    logic              bank_q,    bank_d;
    logic              flip_q,    flip_d;
    logic [ADDR_W-1:0] rdaddr_q,  rdaddr_d;
    logic [ADDR_W-1:0] wraddr_q,  wraddr_d;
    logic              erase_n_q, erase_n_d;
    logic [PIX_W-1:0]  pixel_q,   pixel_d;
    logic              opaque_q,  opaque_d;
    logic [PAIR_W-1:0] pair_q,    pair_d;
    logic [ADDR_W-1:0] last_addr;

    assign pix_en = ~i_EMU_CLK6MPCEN_n;

    // Last pair of the line depends on scan direction; addresses never wrap.
    assign last_addr = flip_q ? '0 : ADDR_TOP;

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        flip_d    = flip_q;
        rdaddr_d  = rdaddr_q;
        wraddr_d  = wraddr_q;
        erase_n_d = 1'b1;
        pixel_d   = '0;
        pair_d    = pair_q;

        if (i_LINESTART) begin
            // Restart takes priority over any line in flight; no erase here.
            bank_d   = ~bank_q;
            flip_d   = i_FLIP;
            rdaddr_d = i_FLIP ? ADDR_TOP : '0;
            state_d  = ST_WAIT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_WAIT: begin
                    // RAM data for the first pair arrives one enable later.
                    state_d = ST_RUN0;
                end
                ST_RUN0: begin
                    pair_d    = {i_QA, i_QB};
                    pixel_d   = flip_q ? i_QB : i_QA;
                    wraddr_d  = rdaddr_q;
                    erase_n_d = ~i_ERASE_EN;
                    if (rdaddr_q != last_addr) begin
                        rdaddr_d = flip_q ? (rdaddr_q - ADDR_W'(1))
                                          : (rdaddr_q + ADDR_W'(1));
                    end
                    state_d = ST_RUN1;
                end
                ST_RUN1: begin
                    // wraddr_q holds the pair just captured, so it marks the end.
                    pixel_d = flip_q ? pair_q[PAIR_W-1:PIX_W] : pair_q[PIX_W-1:0];
                    state_d = (wraddr_q == last_addr) ? ST_IDLE : ST_RUN0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        opaque_d = (pixel_d[3:0] != 4'h0);
    end

    // State register; advances only on pixel enables.
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_RST) begin
        if (i_EMU_RST) begin
            state_q   <= ST_IDLE;
            bank_q    <= 1'b0;
            flip_q    <= 1'b0;
            rdaddr_q  <= '0;
            wraddr_q  <= '0;
            erase_n_q <= 1'b1;
            pixel_q   <= '0;
            opaque_q  <= 1'b0;
            pair_q    <= '0;
        end else if (pix_en) begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            flip_q    <= flip_d;
            rdaddr_q  <= rdaddr_d;
            wraddr_q  <= wraddr_d;
            erase_n_q <= erase_n_d;
            pixel_q   <= pixel_d;
            opaque_q  <= opaque_d;
            pair_q    <= pair_d;
        end
    end

    assign o_BANK    = bank_q;
    assign o_RDADDR  = rdaddr_q;
    assign o_WRADDR  = wraddr_q;
    assign o_ERASE_n = erase_n_q;
    assign o_PIXEL   = pixel_q;
    assign o_OPAQUE  = opaque_q;

endmodule
